// File: rtl/ps2_packet_assembler.sv
// PS/2 mouse packet assembler: finds the sync byte, collects PKT_BYTES bytes
// and publishes complete packets only, aborting partial packets after an idle gap.
module ps2_packet_assembler #(
   parameter int PKT_BYTES = 3,
   parameter int SYNC_BIT  = 3,
   parameter int TIMEOUT   = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in,
   input  logic                   in_valid,
   output logic [8*PKT_BYTES-1:0] out_bytes,
   output logic                   done,
   output logic                   timeout_err,
   output logic [7:0]             drop_cnt,
   output logic [1:0]             state_dbg
);

   localparam int IDX_W = $clog2(PKT_BYTES);
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   localparam int BUF_W = 8 * PKT_BYTES;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      COLLECT = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic [BUF_W-1:0]   buf_q, buf_d;
   logic [BUF_W-1:0]   out_q, out_d;
   logic [7:0]         drop_q, drop_d;
   logic               tmo_q, tmo_d;

   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [8:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + b;
      return sum[8] ? 8'hFF : sum[7:0];
   endfunction

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      buf_d   = buf_q;
      out_d   = out_q;
      drop_d  = drop_q;
      tmo_d   = 1'b0;
      unique case (state_q)
         SEARCH, DONE: begin
            state_d = SEARCH;
            if (in_valid) begin
               if (in[SYNC_BIT]) begin
                  buf_d[BUF_W-1 -: 8] = in;
                  idx_d   = IDX_W'(1);
                  gap_d   = '0;
                  state_d = COLLECT;
               end else begin
                  drop_d = sat_add(drop_q, 9'd1);
               end
            end
         end
         COLLECT: begin
            if (in_valid) begin
               gap_d = '0;
               // Byte idx lands at its MSB-first slot; the loop keeps slices constant.
               for (int i = 1; i < PKT_BYTES; i++) begin
                  if (idx_q == IDX_W'(i)) begin
                     buf_d[8*(PKT_BYTES-1-i) +: 8] = in;
                  end
               end
               if (idx_q == IDX_W'(PKT_BYTES - 1)) begin
                  state_d = DONE;
                  out_d   = buf_d;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (gap_q == GAP_W'(TIMEOUT - 1)) begin
               // This idle cycle brings the gap to TIMEOUT: drop the bytes held.
               state_d = SEARCH;
               tmo_d   = 1'b1;
               drop_d  = sat_add(drop_q, 9'(idx_q));
               idx_d   = '0;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = SEARCH;
            idx_d   = '0;
            gap_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SEARCH;
         idx_q   <= '0;
         gap_q   <= '0;
         buf_q   <= '0;
         out_q   <= '0;
         drop_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
         buf_q   <= buf_d;
         out_q   <= out_d;
         drop_q  <= drop_d;
         tmo_q   <= tmo_d;
      end
   end

   assign out_bytes   = out_q;
   assign done        = (state_q == DONE);
   assign timeout_err = tmo_q;
   assign drop_cnt    = drop_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Bench for ps2_packet_assembler: a 3-byte/TIMEOUT=4 and a 4-byte/TIMEOUT=6 instance
// share one input stream; a byte-queue model predicts packets, aborts and drop counts.
module tb_ps2_packet_assembler;

   localparam int SYNC = 3;
   localparam int PB_A = 3;
   localparam int TO_A = 4;
   localparam int PB_B = 4;
   localparam int TO_B = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in = 8'h00;
   logic        in_valid = 1'b0;

   logic [23:0] out_a;
   logic        done_a, tmo_a;
   logic [7:0]  drop_a;
   logic [1:0]  state_a;
   logic [31:0] out_b;
   logic        done_b, tmo_b;
   logic [7:0]  drop_b;
   logic [1:0]  state_b;

   ps2_packet_assembler #(.PKT_BYTES(PB_A), .SYNC_BIT(SYNC), .TIMEOUT(TO_A)) dut_a (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .out_bytes(out_a), .done(done_a), .timeout_err(tmo_a),
      .drop_cnt(drop_a), .state_dbg(state_a)
   );

   ps2_packet_assembler #(.PKT_BYTES(PB_B), .SYNC_BIT(SYNC), .TIMEOUT(TO_B)) dut_b (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid),
      .out_bytes(out_b), .done(done_b), .timeout_err(tmo_b),
      .drop_cnt(drop_b), .state_dbg(state_b)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: bytes held so far, idle cycles since the last byte, drops.
   int          held_m [2];
   int          idle_m [2];
   int          drop_m [2];
   logic [31:0] acc_m  [2];
   logic [31:0] mout_m [2];
   int          pend_to [2];
   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   bit          mon_en = 1'b0;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   task automatic model_edge(input int k, input int pb, input int tmo);
      if (reset) begin
         held_m[k] = 0; idle_m[k] = 0; drop_m[k] = 0;
         acc_m[k] = '0; mout_m[k] = '0; pend_to[k] = 0;
         return;
      end
      if (in_valid) begin
         idle_m[k] = 0;
         if (held_m[k] == 0 && !in[SYNC]) begin
            drop_m[k] = sat(drop_m[k] + 1);
         end else begin
            acc_m[k] = {acc_m[k][23:0], in};
            held_m[k]++;
            if (held_m[k] == pb) begin
               mout_m[k] = acc_m[k];
               if (k == 0) exp_q0.push_back(acc_m[k]);
               else        exp_q1.push_back(acc_m[k]);
               held_m[k] = 0;
               acc_m[k] = '0;
            end
         end
      end else if (held_m[k] > 0) begin
         idle_m[k]++;
         if (idle_m[k] == tmo) begin
            drop_m[k] = sat(drop_m[k] + held_m[k]);
            held_m[k] = 0; idle_m[k] = 0; acc_m[k] = '0;
            pend_to[k]++;
         end
      end
   endtask

   always @(posedge clk) begin
      model_edge(0, PB_A, TO_A);
      model_edge(1, PB_B, TO_B);
      if (reset) mon_en = 1'b1;
   end

   task automatic mon_check(input int k, input logic d, input logic t,
                            input logic [31:0] o, input logic [7:0] dc);
      logic        exp_d;
      logic        exp_t;
      logic [31:0] e;
      exp_d = (k == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
      check($sformatf("done_%0d", k), 32'(d), 32'(exp_d));
      if (exp_d) begin
         e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
         check($sformatf("packet_%0d", k), o, e);
      end
      check($sformatf("out_bytes_%0d", k), o, mout_m[k]);
      exp_t = (pend_to[k] > 0);
      if (exp_t) pend_to[k]--;
      check($sformatf("timeout_err_%0d", k), 32'(t), 32'(exp_t));
      check($sformatf("drop_cnt_%0d", k), 32'(dc), 32'(drop_m[k]));
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_check(0, done_a, tmo_a, {8'h00, out_a}, drop_a);
         mon_check(1, done_b, tmo_b, out_b, drop_b);
      end
   end

   task automatic drive(input logic rst, input logic v, input logic [7:0] b);
      @(negedge clk);
      reset = rst;
      in_valid = v;
      in = b;
   endtask

   task automatic send(input logic [7:0] b);
      drive(1'b0, 1'b1, b);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 8'h00);
   endtask

   initial begin
      int r;
      // Reset held with a valid sync byte: the byte must be ignored.
      drive(1'b1, 1'b0, 8'h00);
      drive(1'b1, 1'b1, 8'h08);
      idle(1);
      check("reset_out_a", {8'h00, out_a}, 32'h0);
      check("reset_drop_a", 32'(drop_a), 32'h0);
      check("reset_done_a", 32'(done_a), 32'h0);
      check("reset_tmo_a", 32'(tmo_a), 32'h0);

      // Three-byte packet on consecutive cycles.
      send(8'h08); send(8'h12); send(8'h34);
      idle(1);
      check("pkt3_done", 32'(done_a), 32'h1);
      check("pkt3_out", {8'h00, out_a}, 32'h081234);
      check("pkt3_drop", 32'(drop_a), 32'h0);
      idle(8);

      // Two leading non-sync bytes are dropped.
      do_reset();
      send(8'h00); send(8'h01); send(8'h2C); send(8'h55); send(8'h66);
      idle(1);
      check("resync_done", 32'(done_a), 32'h1);
      check("resync_out", {8'h00, out_a}, 32'h2C5566);
      check("resync_drop", 32'(drop_a), 32'h2);
      idle(8);

      // Back-to-back four-byte packets.
      do_reset();
      send(8'h09); send(8'h01); send(8'h02); send(8'h03);
      send(8'h18);
      check("b2b_done1", 32'(done_b), 32'h1);
      check("b2b_out1", out_b, 32'h09010203);
      send(8'hAA); send(8'hBB); send(8'hCC);
      idle(1);
      check("b2b_done2", 32'(done_b), 32'h1);
      check("b2b_out2", out_b, 32'h18AABBCC);
      idle(8);

      // Idle timeout after two bytes; the last packet stays on out_bytes.
      do_reset();
      send(8'h08); send(8'h12); send(8'h34);
      send(8'h08); send(8'h11);
      idle(4);
      check("tmo_not_yet", 32'(tmo_a), 32'h0);
      idle(1);
      check("tmo_pulse", 32'(tmo_a), 32'h1);
      check("tmo_drop", 32'(drop_a), 32'h2);
      check("tmo_out_kept", {8'h00, out_a}, 32'h081234);
      check("tmo_no_done", 32'(done_a), 32'h0);
      idle(8);

      // Reset in the middle of a packet, then a clean packet.
      send(8'h08); send(8'h11);
      do_reset();
      send(8'h28); send(8'h05); send(8'h06);
      idle(1);
      check("rst_mid_done", 32'(done_a), 32'h1);
      check("rst_mid_out", {8'h00, out_a}, 32'h280506);
      idle(8);

      // Drop counter saturation.
      do_reset();
      for (int i = 0; i < 300; i++) send(8'($urandom) & 8'hF7);
      idle(1);
      check("drop_sat_a", 32'(drop_a), 32'd255);
      check("drop_sat_b", 32'(drop_b), 32'd255);
      idle(2);

      // Randomized traffic with occasional idle bursts and resets.
      do_reset();
      for (int c = 0; c < 4000; c++) begin
         r = $urandom_range(0, 99);
         if (r < 1) begin
            drive(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
         end else if (r < 65) begin
            send(8'($urandom));
         end else if (r < 70) begin
            idle($urandom_range(3, 8));
         end else begin
            idle(1);
         end
      end
      idle(12);
      @(posedge clk);
      @(negedge clk);
      #1;
      check("exp_q0_drained", 32'(exp_q0.size()), 32'h0);
      check("exp_q1_drained", 32'(exp_q1.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_packet_assembler.md
PS2_PACKET_ASSEMBLER -- requirements
Module: ps2_packet_assembler

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 3, meaning bytes per packet (legal 3..4; 4 = scroll-wheel mode).
REQ-002 SHALL have parameter SYNC_BIT, default 3, meaning index of the always-1 bit in the first packet byte.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum idle cycles allowed between bytes of one packet (legal >= 1).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in  input  8  received byte.
REQ-007 SHALL have port in_valid  input  1  qualifies in for exactly the cycle it is high.
REQ-008 SHALL have port out_bytes  output  8*PKT_BYTES  last completed packet; first byte in the most significant 8 bits.
REQ-009 SHALL have port done  output  1  one-cycle pulse marking a new packet on out_bytes.
REQ-010 SHALL have port timeout_err  output  1  one-cycle pulse marking an aborted partial packet.
REQ-011 SHALL have port drop_cnt  output  8  saturating count of discarded bytes.

Function
REQ-012 SHALL implement states SEARCH, COLLECT, DONE, plus byte index idx (0..PKT_BYTES-1) and idle counter gap.
REQ-013 SHALL, in SEARCH or DONE, on in_valid with in[SYNC_BIT]=1, store in as byte 0, set idx=1, clear gap, and enter COLLECT.
REQ-014 SHALL, in SEARCH or DONE, on in_valid with in[SYNC_BIT]=0, discard the byte, increment drop_cnt (saturates at 255), and enter SEARCH.
REQ-015 SHALL, in DONE without in_valid, enter SEARCH.
REQ-016 SHALL, in COLLECT on in_valid, store in as byte idx regardless of in[SYNC_BIT] and clear gap.
REQ-017 SHALL, when the stored byte has idx=PKT_BYTES-1, enter DONE; otherwise increment idx and stay in COLLECT.
REQ-018 SHALL, on entering DONE, copy the full assembly buffer to out_bytes in the same edge.
REQ-019 SHALL assert done for exactly the cycle in DONE, so done is high the cycle after the last byte's in_valid.
REQ-020 SHALL hold out_bytes stable between done pulses; partial packets SHALL never be visible on out_bytes.
REQ-021 SHALL, in COLLECT without in_valid, increment gap.
REQ-022 SHALL, when gap reaches TIMEOUT, abort to SEARCH, pulse timeout_err for one cycle, and add idx (the bytes held) to drop_cnt with saturation.
REQ-023 SHALL give in_valid priority over timeout in the same cycle: the byte is accepted and gap cleared.
REQ-024 SHALL allow back-to-back packets: a valid first byte in the DONE cycle starts the next packet with no lost cycle.
REQ-025 SHALL size idx and gap to the minimum widths covering PKT_BYTES-1 and TIMEOUT.

Reset
REQ-026 SHALL, with reset high at a clock edge, set state SEARCH, idx=0, gap=0, out_bytes=0, done=0, timeout_err=0, drop_cnt=0.
REQ-027 SHALL give reset precedence over in_valid in the same cycle.
REQ-028 SHALL, on reset mid-packet, discard the partial packet without pulsing done or timeout_err.

Verification
REQ-029 SHALL be verified with PKT_BYTES=3, bytes 0x08,0x12,0x34 on consecutive cycles -> done high one cycle after 0x34, out_bytes=0x081234, drop_cnt=0.
REQ-030 SHALL be verified with PKT_BYTES=3, bytes 0x00,0x01,0x2C,0x55,0x66 -> drop_cnt=2, done after 0x66, out_bytes=0x2C5566.
REQ-031 SHALL be verified with PKT_BYTES=4, two back-to-back packets 0x09,0x01,0x02,0x03 then 0x18,0xAA,0xBB,0xCC -> two done pulses 4 cycles apart, out_bytes=0x09010203 then 0x18AABBCC.
REQ-032 SHALL be verified with TIMEOUT=4, byte 0x08 then 0x11, then 4 idle cycles -> timeout_err pulse, drop_cnt=2, no done, out_bytes unchanged.
REQ-033 SHALL be verified with reset asserted after the second byte of a packet, then a full packet 0x28,0x05,0x06 -> no done before reset, done after the new packet, out_bytes=0x280506.
REQ-034 SHALL be verified with 300 non-sync bytes -> drop_cnt saturates at 255, with no wrap to 0.
